fft_peak_detect: RTL and testbench
==================================

# fft_peak_detect

Streaming spectral peak finder sitting directly downstream of `fftmain`. Consumes the FFT output stream (one packed complex bin per clock-enable, frame-aligned by the FFT sync strobe) and computes re²+im² per bin. Tracks the strongest positive-frequency bin (excluding DC) across each frame. At frame end, emits the winning bin index and its magnitude with a one-cycle valid pulse, for LED display and later vibration-frequency logic.

## Interface
- `N_LOG2`, default 6: log2 of FFT length N (64 bins/frame).
- `IW`, default 11: width of each signed real/imag component.
- `MAG_W`, default 2*IW: unsigned magnitude-squared width (holds 2·(−2^(IW−1))² exactly).
- `sys_clock`  in  1: single clock for the whole block.
- `reset`  in  1: synchronous, active-high reset.
- `in_ce`  in  1: bin strobe; `in_data`/`in_sync` are sampled only when high (driven by the same strobe as the FFT output, `FFT_osync` path).
- `in_sync`  in  1: qualifies bin 0 of a frame (meaningful only with `in_ce`).
- `in_data`  in  2*IW: `{re[IW-1:0], im[IW-1:0]}`, two's complement.
- `peak_bin`  out  N_LOG2: index of the strongest bin in the last completed frame.
- `peak_mag`  out  MAG_W: re²+im² of that bin.
- `out_valid`  out  1: one-cycle pulse when `peak_bin`/`peak_mag` update.
- `resync_err`  out  1: sticky; set when `in_sync` arrives mid-frame; cleared only by reset.

## Operation
- States: `WAIT_SYNC` (reset state), `ACCUM`.
- `WAIT_SYNC`: ignore all `in_ce` samples until `in_ce && in_sync`; that sample is bin 0, counter ← 1, go to `ACCUM`.
- `ACCUM`: each `in_ce` sample gets bin index = counter; counter increments, wrapping N−1 → 0.
- `in_ce && in_sync` with counter ≠ 0: abort current frame (no output), set `resync_err`, treat sample as bin 0, clear running max.
- `in_ce && in_sync` with counter = 0: normal frame start.
- Magnitude: sign-extend, square each component, sum unsigned into MAG_W bits; no truncation or saturation.
- Candidate bins: 1 … N/2−1 only (real input; DC and mirror half skipped). Bin 1 always loads the running max unconditionally; bins 2 … N/2−1 replace it only if strictly greater (ties → lowest bin).
- Bin N−1 marks frame end: the registered result (from bins 1 … N/2−1) moves to outputs, `out_valid` pulses.
- All-zero frame → `peak_bin`=1, `peak_mag`=0, `out_valid` still pulses.
- Gaps of any length between `in_ce` strobes are legal; the pipeline advances every clock with a valid bit and does not depend on `in_ce` spacing.

## Timing
- Reset values: `peak_bin`=0, `peak_mag`=0, `out_valid`=0, `resync_err`=0, state `WAIT_SYNC`, pipeline valids 0.
- Pipeline: edge E0 captures re/im, bin index, last flag. E1 registers squares. E2 registers sum. E3 performs compare/update and loads the outputs on the last bin.
- `out_valid` is high for exactly the one cycle after E3, i.e. 3 clocks after the edge sampling bin N−1.
- Back-to-back frames (`in_ce` every cycle) are sustained with no bubbles. The next frame's bin 1 may reach the compare stage at the same edge the outputs load: outputs take the completed frame; running max takes the new bin 1.
- Reset mid-frame: all pipeline contents discarded; no `out_valid` until a full frame after the next sync.

## Structure
- Shared package `vib_pkg`: `N_LOG2`, `IW`, `MAG_W` defaults, state enum `{WAIT_SYNC, ACCUM}`, helper to unpack re/im from the 2·IW word.
- One sub-module `fft_mag_sq`: two-stage pipelined re²+im² with valid/tag passthrough (tag = bin index + last flag). Top holds the FSM, counter and peak tracker.

## Test plan
- Reset, then a frame with `in_ce` every cycle and sync on bin 0; bin 5 = {re=100, im=0}, others 0 → `out_valid` pulse 3 cycles after bin 63 sample, `peak_bin`=5, `peak_mag`=10000.
- Bins 3 and 7 both {re=−1024, im=−1024}, others 0 → `peak_bin`=3, `peak_mag`=2097152 (tie, no overflow).
- Bin 0 = {1000,0}, bin 40 = {900,0}, bin 2 = {10,0} → `peak_bin`=2, `peak_mag`=100 (DC and upper half ignored).
- Samples before first sync, then `in_ce` every 4th cycle → pre-sync data ignored; one `out_valid` per 64 strobes; results match the in-frame data.
- `in_sync` at counter=20 → no `out_valid` for the aborted frame, `resync_err`=1 and stays 1; the next complete frame reports correctly.
- Two back-to-back frames, peaks at bin 9 then bin 30 → two `out_valid` pulses 64 cycles apart reporting 9 then 30; reset asserted mid-third-frame → no further pulse, outputs return to 0.

Source files
------------

// File: rtl/vib_pkg.sv
// Shared types and defaults for the vibration-analysis datapath downstream of fftmain.
package vib_pkg;

  localparam int N_LOG2_DEF = 6;
  localparam int IW_DEF     = 11;
  localparam int MAG_W_DEF  = 2 * IW_DEF;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    ACCUM     = 1'b1
  } state_t;

  typedef struct packed {
    logic signed [IW_DEF-1:0] re;
    logic signed [IW_DEF-1:0] im;
  } cplx_t;

  // FFT output word is {re, im}, both two's complement.
  function automatic cplx_t unpack_cplx(input logic [2*IW_DEF-1:0] word);
    cplx_t c;
    c.re = word[2*IW_DEF-1 -: IW_DEF];
    c.im = word[IW_DEF-1:0];
    return c;
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage pipelined re^2 + im^2 with a tag (bin index + last flag) travelling alongside.
module fft_mag_sq #(
  parameter int IW    = 11,
  parameter int MAG_W = 2 * IW,
  parameter int TAG_W = 7
) (
  input  logic                 sys_clock,
  input  logic                 reset,
  input  logic                 vld_p0,
  input  logic signed [IW-1:0] re_p0,
  input  logic signed [IW-1:0] im_p0,
  input  logic [TAG_W-1:0]     tag_p0,
  output logic                 vld_p2,
  output logic [MAG_W-1:0]     mag_p2,
  output logic [TAG_W-1:0]     tag_p2
);

  localparam int SQ_W = 2 * IW;

  logic               vld_p1;
  logic [SQ_W-1:0]    re_sq_p1;
  logic [SQ_W-1:0]    im_sq_p1;
  logic [TAG_W-1:0]   tag_p1;

  // A square is never negative and at most 2^(2IW-2), so it fits SQ_W unsigned bits.
  function automatic logic [SQ_W-1:0] square(input logic signed [IW-1:0] x);
    logic signed [SQ_W-1:0] xe;
    logic signed [SQ_W-1:0] prod;
    xe   = {{IW{x[IW-1]}}, x};
    prod = xe * xe;
    return $unsigned(prod);
  endfunction

  function automatic logic [MAG_W-1:0] add_mag(input logic [SQ_W-1:0] a,
                                               input logic [SQ_W-1:0] b);
    return MAG_W'(a) + MAG_W'(b);
  endfunction

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage p0 -> p1: squares
  always_ff @(posedge sys_clock) begin
    re_sq_p1 <= square(re_p0);
    im_sq_p1 <= square(im_p0);
    tag_p1   <= tag_p0;
  end

  // Stage p1 -> p2: sum
  always_ff @(posedge sys_clock) begin
    mag_p2 <= add_mag(re_sq_p1, im_sq_p1);
    tag_p2 <= tag_p1;
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Streaming peak finder: strongest positive-frequency bin (DC excluded) of each FFT frame.
module fft_peak_detect
  import vib_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int IW     = IW_DEF,
  parameter int MAG_W  = MAG_W_DEF
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              in_ce,
  input  logic              in_sync,
  input  logic [2*IW-1:0]   in_data,
  output logic [N_LOG2-1:0] peak_bin,
  output logic [MAG_W-1:0]  peak_mag,
  output logic              out_valid,
  output logic              resync_err
);

  localparam int N     = 1 << N_LOG2;
  localparam int TAG_W = N_LOG2 + 1;
  localparam logic [N_LOG2-1:0] LAST_BIN  = N_LOG2'(N - 1);
  localparam logic [N_LOG2-1:0] FIRST_BIN = N_LOG2'(1);
  localparam logic [N_LOG2-1:0] CAND_LO   = N_LOG2'(2);
  localparam logic [N_LOG2-1:0] CAND_HI   = N_LOG2'(N / 2 - 1);

  logic signed [IW-1:0] re_in;
  logic signed [IW-1:0] im_in;

  if (IW == IW_DEF) begin : g_pkg_unpack
    cplx_t c_in;
    assign c_in  = unpack_cplx(in_data);
    assign re_in = c_in.re;
    assign im_in = c_in.im;
  end else begin : g_slice_unpack
    assign re_in = in_data[2*IW-1 -: IW];
    assign im_in = in_data[IW-1:0];
  end

  state_t               state;
  logic [N_LOG2-1:0]    cnt;
  logic                 vld_p0;
  logic signed [IW-1:0] re_p0;
  logic signed [IW-1:0] im_p0;
  logic [N_LOG2-1:0]    bin_p0;
  logic                 last_p0;

  // Stage in -> p0: frame tracking and sample capture
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state      <= WAIT_SYNC;
      cnt        <= '0;
      vld_p0     <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      if (in_ce) begin
        case (state)
          WAIT_SYNC: begin
            if (in_sync) begin
              state  <= ACCUM;
              cnt    <= FIRST_BIN;
              vld_p0 <= 1'b1;
            end
          end
          ACCUM: begin
            vld_p0 <= 1'b1;
            if (in_sync) begin
              // A sync mid-frame abandons the frame; its last bin never arrives.
              if (cnt != '0) resync_err <= 1'b1;
              cnt <= FIRST_BIN;
            end else begin
              cnt <= cnt + FIRST_BIN;
            end
          end
          default: state <= WAIT_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clock) begin
    if (in_ce) begin
      re_p0   <= re_in;
      im_p0   <= im_in;
      bin_p0  <= in_sync ? '0 : cnt;
      last_p0 <= !in_sync && (cnt == LAST_BIN);
    end
  end

  logic                 vld_p2;
  logic [MAG_W-1:0]     mag_p2;
  logic [TAG_W-1:0]     tag_p2;
  logic [N_LOG2-1:0]    bin_p2;
  logic                 last_p2;

  fft_mag_sq #(
    .IW    (IW),
    .MAG_W (MAG_W),
    .TAG_W (TAG_W)
  ) u_mag_sq (
    .sys_clock (sys_clock),
    .reset     (reset),
    .vld_p0    (vld_p0),
    .re_p0     (re_p0),
    .im_p0     (im_p0),
    .tag_p0    ({last_p0, bin_p0}),
    .vld_p2    (vld_p2),
    .mag_p2    (mag_p2),
    .tag_p2    (tag_p2)
  );

  assign {last_p2, bin_p2} = tag_p2;

  logic              is_first;
  logic              is_cand;
  logic [N_LOG2-1:0] max_bin;
  logic [MAG_W-1:0]  max_mag;

  assign is_first = (bin_p2 == FIRST_BIN);
  assign is_cand  = (bin_p2 >= CAND_LO) && (bin_p2 <= CAND_HI);

  // Stage p2 -> out: running max; strict compare keeps the lowest bin on ties
  always_ff @(posedge sys_clock) begin
    if (vld_p2 && (is_first || (is_cand && (mag_p2 > max_mag)))) begin
      max_bin <= bin_p2;
      max_mag <= mag_p2;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      peak_bin  <= '0;
      peak_mag  <= '0;
    end else begin
      out_valid <= vld_p2 && last_p2;
      if (vld_p2 && last_p2) begin
        peak_bin <= max_bin;
        peak_mag <= max_mag;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: randomized frames against a frame-level reference model.
module tb_fft_peak_detect;

  localparam int N_LOG2 = 6;
  localparam int IW     = 11;
  localparam int MAG_W  = 2 * IW;
  localparam int N      = 1 << N_LOG2;

  logic              clk;
  logic              reset;
  logic              in_ce;
  logic              in_sync;
  logic [2*IW-1:0]   in_data;
  logic [N_LOG2-1:0] peak_bin;
  logic [MAG_W-1:0]  peak_mag;
  logic              out_valid;
  logic              resync_err;

  fft_peak_detect #(
    .N_LOG2 (N_LOG2),
    .IW     (IW),
    .MAG_W  (MAG_W)
  ) dut (
    .sys_clock  (clk),
    .reset      (reset),
    .in_ce      (in_ce),
    .in_sync    (in_sync),
    .in_data    (in_data),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag),
    .out_valid  (out_valid),
    .resync_err (resync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int     bin;
    longint mag;
    longint cyc;
  } exp_t;

  exp_t   q[$];
  bit     in_frame = 1'b0;
  int     m_cnt    = 0;
  longint fmag[N];
  int     fr_re[N];
  int     fr_im[N];

  task automatic chk(input string name, input logic [63:0] act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Frame-level model: collect a whole frame of magnitudes, then search bins 1..N/2-1.
  task automatic model_sample(input bit sync, input int re, input int im);
    int best;
    if (!in_frame && !sync) return;
    if (sync) begin
      in_frame = 1'b1;
      m_cnt    = 0;
    end
    fmag[m_cnt] = longint'(re) * re + longint'(im) * im;
    if (m_cnt == N - 1) begin
      best = 1;
      for (int b = 2; b < N / 2; b++)
        if (fmag[b] > fmag[best]) best = b;
      q.push_back('{bin: best, mag: fmag[best], cyc: cyc + 4});
    end
    m_cnt = (m_cnt + 1) % N;
  endtask

  task automatic drive(input bit ce, input bit sync, input int re, input int im);
    logic [IW-1:0] r;
    logic [IW-1:0] i;
    @(posedge clk);
    #1;
    r       = re[IW-1:0];
    i       = im[IW-1:0];
    in_ce   = ce;
    in_sync = sync;
    in_data = {r, i};
    if (ce) model_sample(sync, re, im);
  endtask

  function automatic int rnd_full();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom_range(0, 1)), rnd_full(), rnd_full());
  endtask

  task automatic clear_frame();
    for (int b = 0; b < N; b++) begin
      fr_re[b] = 0;
      fr_im[b] = 0;
    end
  endtask

  // mode 0: full-range values; mode 1: tiny range so ties are frequent
  task automatic rand_frame(input int mode);
    for (int b = 0; b < N; b++) begin
      if (mode == 0) begin
        fr_re[b] = rnd_full();
        fr_im[b] = rnd_full();
      end else begin
        fr_re[b] = int'($urandom_range(0, 6)) - 3;
        fr_im[b] = int'($urandom_range(0, 6)) - 3;
      end
    end
  endtask

  // gap < 0 selects a random 0..3 idle cycles after each strobe
  task automatic send_frame(input int nbins, input int gap);
    int g;
    for (int b = 0; b < nbins; b++) begin
      drive(1'b1, b == 0, fr_re[b], fr_im[b]);
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      if (g > 0) idle(g);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_ce    = 1'b0;
    in_sync  = 1'b0;
    in_frame = 1'b0;
    m_cnt    = 0;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_pulse: out_valid=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = q.pop_front();
        chk("peak_bin", 64'(peak_bin), e.bin);
        chk("peak_mag", 64'(peak_mag), e.mag);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    in_ce   = 1'b0;
    in_sync = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    chk("rst_peak_bin", 64'(peak_bin), 0);
    chk("rst_peak_mag", 64'(peak_mag), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_resync_err", 64'(resync_err), 0);

    clear_frame();
    fr_re[5] = 100;
    send_frame(N, 0);
    idle(6);
    chk("single_bin", 64'(peak_bin), 5);
    chk("single_mag", 64'(peak_mag), 10000);

    clear_frame();
    fr_re[3] = -1024; fr_im[3] = -1024;
    fr_re[7] = -1024; fr_im[7] = -1024;
    send_frame(N, 0);
    idle(6);
    chk("tie_bin", 64'(peak_bin), 3);
    chk("tie_mag", 64'(peak_mag), 2097152);

    clear_frame();
    fr_re[0] = 1000; fr_re[40] = 900; fr_re[2] = 10;
    send_frame(N, 0);
    idle(6);
    chk("dc_upper_bin", 64'(peak_bin), 2);
    chk("dc_upper_mag", 64'(peak_mag), 100);
    chk("no_resync", 64'(resync_err), 0);

    do_reset();
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, rnd_full(), rnd_full());
    rand_frame(0);
    send_frame(N, 3);
    rand_frame(1);
    send_frame(N, 3);
    idle(6);

    rand_frame(0);
    send_frame(20, 0);
    rand_frame(0);
    send_frame(N, 0);
    idle(6);
    chk("resync_set", 64'(resync_err), 1);
    rand_frame(1);
    send_frame(N, -1);
    idle(6);
    chk("resync_sticky", 64'(resync_err), 1);

    for (int f = 0; f < 4; f++) begin
      rand_frame(f % 2);
      send_frame(N, (f < 2) ? 0 : -1);
    end
    idle(6);

    do_reset();
    chk("resync_cleared", 64'(resync_err), 0);
    clear_frame();
    fr_re[9] = 500; fr_im[9] = -300;
    send_frame(N, 0);
    clear_frame();
    fr_re[30] = -700;
    send_frame(N, 0);
    clear_frame();
    fr_re[12] = 50;
    send_frame(30, 0);
    chk("b2b_bin", 64'(peak_bin), 30);
    chk("b2b_mag", 64'(peak_mag), 490000);
    do_reset();
    idle(10);
    chk("midrst_bin", 64'(peak_bin), 0);
    chk("midrst_mag", 64'(peak_mag), 0);

    rand_frame(0);
    send_frame(N, 0);
    idle(8);
    chk("scoreboard_drained", 64'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
